// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int RF_XLEN     = 32;
  localparam int RF_NUM_REGS = 32;

  // Address width that exactly spans num_regs entries (at least 1 bit).
  function automatic int rf_aw(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int RF_AW = rf_aw(RF_NUM_REGS);

  typedef logic [RF_AW-1:0]   rf_addr_t;
  typedef logic [RF_XLEN-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one flag per register, set when the register is issued as a
// destination and cleared when its result is written back.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NR_READ  = 2,
  parameter int NR_WRITE = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rstn_i,
  input  logic [NR_WRITE-1:0] we_i,
  input  logic [AW-1:0]       wr_addr_i [NR_WRITE],
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic [AW-1:0]       rd_addr_i [NR_READ],
  output logic [NR_READ-1:0]  rd_busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy state: writes clear, then a reserve sets (newer producer wins).
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see earlier
    // results; assigning a full default first keeps every path covered (no latch).
    busy_d = busy_q;
    for (int w = 0; w < NR_WRITE; w++) begin
      if (we_i[w]) busy_d[wr_addr_i[w]] = 1'b0;
    end
    if (rsv_i) busy_d[rsv_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy flags, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rstn_i) begin
    // NOTE: clocked state uses non-blocking '<=' so all flops update together.
    if (!rstn_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // Per-port busy lookup; a same-cycle matching write retires the result early
  // unless the same register is being re-reserved this cycle.
  always_comb begin
    rd_busy_o = '0;
    for (int r = 0; r < NR_READ; r++) begin
      rd_busy_o[r] = busy_q[rd_addr_i[r]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NR_WRITE; w++) begin
          if (we_i[w] && (wr_addr_i[w] == rd_addr_i[r]))
            rd_busy_o[r] = rsv_i && (rsv_addr_i == rd_addr_i[r]);
        end
      end
      if (rd_addr_i[r] == '0) rd_busy_o[r] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write->read bypass and a
// per-register busy scoreboard. Register 0 reads as zero and ignores writes.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NR_READ  = 2,
  parameter int NR_WRITE = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rstn_i,
  input  logic [AW-1:0]       rd_addr_i [NR_READ],
  output logic [XLEN-1:0]     rd_data_o [NR_READ],
  output logic [NR_READ-1:0]  rd_busy_o,
  input  logic [NR_WRITE-1:0] we_i,
  input  logic [AW-1:0]       wr_addr_i [NR_WRITE],
  input  logic [XLEN-1:0]     wr_data_i [NR_WRITE],
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Write-port priority: ports applied in ascending order so the highest wins.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NR_WRITE; w++) begin
      if (we_i[w] && (wr_addr_i[w] != '0)) regs_d[wr_addr_i[w]] = wr_data_i[w];
    end
    regs_d[0] = '0;
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rstn_i) begin
    // NOTE: the array is built from resettable flops (not a RAM macro) because
    // every register must read zero straight out of reset.
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux with optional same-cycle bypass from the highest matching write port.
  always_comb begin
    for (int r = 0; r < NR_READ; r++) begin
      rd_data_o[r] = regs_q[rd_addr_i[r]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NR_WRITE; w++) begin
          if (we_i[w] && (wr_addr_i[w] == rd_addr_i[r])) rd_data_o[r] = wr_data_i[w];
        end
      end
      if (rd_addr_i[r] == '0) rd_data_o[r] = '0;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NR_READ  (NR_READ),
    .NR_WRITE (NR_WRITE),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .we_i       (we_i),
    .wr_addr_i  (wr_addr_i),
    .rsv_i      (rsv_i),
    .rsv_addr_i (rsv_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share one stimulus stream.
//   dut_a: 3 read ports, 2 write ports, bypass on
//   dut_b: 2 read ports, 1 write port,  bypass off (sees read ports 0..1, write port 0)
module tb_regfile_mp;
  import rf_pkg::*;

  localparam int NRA = 3, NWA = 2, NRB = 2, NWB = 1;

  logic clk = 1'b0;
  logic rstn_i = 1'b1;

  rf_addr_t       rd_addr [NRA];
  logic [NWA-1:0] we;
  rf_addr_t       wr_addr [NWA];
  rf_data_t       wr_data [NWA];
  logic           rsv;
  rf_addr_t       rsv_addr;

  rf_data_t       rd_data_a [NRA];
  logic [NRA-1:0] rd_busy_a;

  rf_addr_t       rd_addr_b [NRB];
  rf_addr_t       wr_addr_b [NWB];
  rf_data_t       wr_data_b [NWB];
  rf_data_t       rd_data_b [NRB];
  logic [NRB-1:0] rd_busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_addr_b[0] = rd_addr[0];
  assign rd_addr_b[1] = rd_addr[1];
  assign wr_addr_b[0] = wr_addr[0];
  assign wr_data_b[0] = wr_data[0];

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .NR_READ(NRA), .NR_WRITE(NWA), .BYPASS(1)) dut_a (
    .clk(clk), .rstn_i(rstn_i),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr)
  );

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .NR_READ(NRB), .NR_WRITE(NWB), .BYPASS(0)) dut_b (
    .clk(clk), .rstn_i(rstn_i),
    .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .we_i(we[0:0]), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural state per instance) ----------------
  rf_data_t m_mem  [2][32];
  bit       m_busy [2][32];

  function automatic int nw_of(input int d);
    return (d == 0) ? NWA : NWB;
  endfunction

  // Value a read of register a must return right now.
  function automatic rf_data_t exp_data(input int d, input rf_addr_t a);
    if (a == 0) return '0;
    if (d == 0) begin
      for (int w = nw_of(d) - 1; w >= 0; w--)
        if (we[w] && wr_addr[w] == a) return wr_data[w];
    end
    return m_mem[d][a];
  endfunction

  function automatic bit exp_busy(input int d, input rf_addr_t a);
    if (a == 0) return 1'b0;
    if (d == 0) begin
      for (int w = nw_of(d) - 1; w >= 0; w--)
        if (we[w] && wr_addr[w] == a) return rsv && (rsv_addr == a);
    end
    return m_busy[d][a];
  endfunction

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 32; i++) begin
          m_mem[d][i]  = '0;
          m_busy[d][i] = 1'b0;
        end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int w = 0; w < nw_of(d); w++) begin
          if (we[w]) begin
            if (wr_addr[w] != 0) m_mem[d][wr_addr[w]] = wr_data[w];
            m_busy[d][wr_addr[w]] = 1'b0;
          end
        end
        if (rsv && rsv_addr != 0) m_busy[d][rsv_addr] = 1'b1;
      end
    end
  end

  // Compare every read port of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int r = 0; r < NRA; r++) begin
      check($sformatf("a.rd_data[%0d]", r), rd_data_a[r], exp_data(0, rd_addr[r]));
      check($sformatf("a.rd_busy[%0d]", r), {31'd0, rd_busy_a[r]}, {31'd0, exp_busy(0, rd_addr[r])});
    end
    for (int r = 0; r < NRB; r++) begin
      check($sformatf("b.rd_data[%0d]", r), rd_data_b[r], exp_data(1, rd_addr[r]));
      check($sformatf("b.rd_busy[%0d]", r), {31'd0, rd_busy_b[r]}, {31'd0, exp_busy(1, rd_addr[r])});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we = '0; rsv = 1'b0; rsv_addr = '0;
    for (int i = 0; i < NRA; i++) rd_addr[i] = '0;
    for (int i = 0; i < NWA; i++) begin wr_addr[i] = '0; wr_data[i] = '0; end
  endtask

  task automatic step();   // drive just after the rising edge
    @(posedge clk); #1;
  endtask

  task automatic mid();    // sample just after the falling edge
    @(negedge clk); #1;
  endtask

  function automatic rf_addr_t pick();
    if ($urandom_range(0, 2) != 0) return rf_addr_t'($urandom_range(0, 3));
    return rf_addr_t'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    // Power-up reset
    #2 rstn_i = 1'b0;
    #1;
    check("reset a.data0", rd_data_a[0], 32'h0);
    check("reset a.busy0", {31'd0, rd_busy_a[0]}, 32'h0);
    step(); step();
    rstn_i = 1'b1;

    // Same-cycle bypass vs stored value
    step();
    we[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'hDEAD_BEEF;
    rd_addr[0] = 5; rd_addr[1] = 5; rd_addr[2] = 5;
    mid();
    check("bypass a now", rd_data_a[0], 32'hDEAD_BEEF);
    check("nobypass b now", rd_data_b[0], 32'h0);
    step(); idle(); rd_addr[0] = 5;
    mid();
    check("a after write", rd_data_a[0], 32'hDEAD_BEEF);
    check("b after write", rd_data_b[0], 32'hDEAD_BEEF);

    // x0 is hardwired; x31 is ordinary
    step(); idle();
    we[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 32'hFFFF_FFFF;
    mid();
    check("x0 bypass a", rd_data_a[0], 32'h0);
    step(); idle();
    mid();
    check("x0 a", rd_data_a[0], 32'h0);
    check("x0 b", rd_data_b[0], 32'h0);
    step(); idle();
    we[0] = 1'b1; wr_addr[0] = 31; wr_data[0] = 32'h1234;
    step(); idle(); rd_addr[0] = 31;
    mid();
    check("x31 a", rd_data_a[0], 32'h1234);
    check("x31 b", rd_data_b[0], 32'h1234);

    // Two ports, same address: highest port wins
    step(); idle();
    we = 2'b11; wr_addr[0] = 7; wr_data[0] = 32'h11; wr_addr[1] = 7; wr_data[1] = 32'h22;
    rd_addr[0] = 7;
    mid();
    check("dual wr bypass a", rd_data_a[0], 32'h22);
    check("dual wr old b", rd_data_b[0], 32'h0);
    step(); idle(); rd_addr[0] = 7;
    mid();
    check("dual wr a", rd_data_a[0], 32'h22);
    check("single wr b", rd_data_b[0], 32'h11);

    // Scoreboard
    step(); idle(); rsv = 1'b1; rsv_addr = 9; rd_addr[0] = 9;
    mid();
    check("rsv same cycle a", {31'd0, rd_busy_a[0]}, 32'h0);
    step(); idle(); rd_addr[0] = 9;
    mid();
    check("rsv busy a", {31'd0, rd_busy_a[0]}, 32'h1);
    check("rsv busy b", {31'd0, rd_busy_b[0]}, 32'h1);
    step(); idle();
    we[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'h99; rsv = 1'b1; rsv_addr = 9; rd_addr[0] = 9;
    mid();
    check("wr+rsv busy a", {31'd0, rd_busy_a[0]}, 32'h1);
    check("wr+rsv data a", rd_data_a[0], 32'h99);
    step(); idle();
    we[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'hAB; rd_addr[0] = 9;
    mid();
    check("wr clears busy a now", {31'd0, rd_busy_a[0]}, 32'h0);
    check("still busy b now", {31'd0, rd_busy_b[0]}, 32'h1);
    check("old data b", rd_data_b[0], 32'h99);
    step(); idle(); rd_addr[0] = 9;
    mid();
    check("busy cleared a", {31'd0, rd_busy_a[0]}, 32'h0);
    check("busy cleared b", {31'd0, rd_busy_b[0]}, 32'h0);
    check("data9 a", rd_data_a[0], 32'hAB);
    check("data9 b", rd_data_b[0], 32'hAB);
    step(); idle(); rsv = 1'b1; rsv_addr = 0;
    step(); idle();
    mid();
    check("rsv x0 busy a", {31'd0, rd_busy_a[0]}, 32'h0);

    // Mixed random traffic, checked by the per-cycle compare
    for (int n = 0; n < 400; n++) begin
      step();
      we = 2'($urandom_range(0, 3));
      for (int w = 0; w < NWA; w++) begin
        wr_addr[w] = pick();
        wr_data[w] = $urandom;
      end
      rsv      = ($urandom_range(0, 2) == 0);
      rsv_addr = pick();
      for (int r = 0; r < NRA; r++) rd_addr[r] = pick();
    end

    // Asynchronous reset mid-cycle clears data and busy immediately
    step(); idle();
    we[0] = 1'b1; wr_addr[0] = 12; wr_data[0] = 32'hCAFE; rsv = 1'b1; rsv_addr = 13;
    step(); idle(); rd_addr[0] = 12; rd_addr[1] = 13;
    mid();
    check("pre-reset data a", rd_data_a[0], 32'hCAFE);
    check("pre-reset busy a", {31'd0, rd_busy_a[1]}, 32'h1);
    rstn_i = 1'b0;
    #1;
    check("midreset data a", rd_data_a[0], 32'h0);
    check("midreset busy a", {31'd0, rd_busy_a[1]}, 32'h0);
    check("midreset data b", rd_data_b[0], 32'h0);
    #1 rstn_i = 1'b1;
    #1;
    check("postreset data a", rd_data_a[0], 32'h0);
    check("postreset busy b", {31'd0, rd_busy_b[1]}, 32'h0);
    step();
    mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
